// File: rtl/console_uart_tx_pkg.sv
// Shared constants for the console UART transmitter: FSM encodings used by the
// RTL and decoded by the simulation loggers, plus an elaboration-time helper.
package console_uart_tx_pkg;

  localparam int UART_STATE_LEN = 2;

  localparam logic [UART_STATE_LEN-1:0] UART_IDLE  = 2'd0;
  localparam logic [UART_STATE_LEN-1:0] UART_START = 2'd1;
  localparam logic [UART_STATE_LEN-1:0] UART_DATA  = 2'd2;
  localparam logic [UART_STATE_LEN-1:0] UART_STOP  = 2'd3;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/console_uart_tx_fifo.sv
// Synchronous byte FIFO for console_uart_tx; rdata shows the head entry
// combinationally so a pop and its data use the same edge.
module console_fifo
  import console_uart_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (count_q == {CW{1'b0}});
  assign full  = (count_q == CNT_MAX);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  // A full FIFO still accepts when the head leaves on the same edge.
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/console_uart_tx.sv
// Console-port UART transmitter: buffers console bytes and sends them as 8N1
// frames on uart_tx so FPGA builds echo the simulation console output.
module console_uart_tx
  import console_uart_tx_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          console_we,
  input  logic [XLEN-1:0]               console_wdata,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BCNT_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BCNT_ONE  = BW'(1);

  if (CLKS_PER_BIT < 2 || !is_pow2(FIFO_DEPTH)) begin : g_bad_param
    $error("console_uart_tx: CLKS_PER_BIT must be >= 2 and FIFO_DEPTH a power of two");
  end

  logic [UART_STATE_LEN-1:0] state_q, state_d;
  logic [BW-1:0]             bcnt_q, bcnt_d;
  logic [2:0]                bidx_q, bidx_d;
  logic [7:0]                shreg_q, shreg_d;
  logic                      tx_q, tx_d;
  logic                      overflow_q, overflow_d;

  logic                      pop_s;
  logic                      push_s;
  logic                      full_s;
  logic                      empty_s;
  logic                      bcnt_zero_s;
  logic [7:0]                rdata_s;
  logic [CW-1:0]             count_s;
  logic                      unused_wdata_s;

  assign unused_wdata_s = ^console_wdata[XLEN-1:8];

  console_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (console_wdata[7:0]),
    .rdata (rdata_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign push_s      = console_we;
  assign bcnt_zero_s = (bcnt_q == {BW{1'b0}});
  assign overflow_d  = overflow_q | (console_we & full_s & ~pop_s);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    pop_s   = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          shreg_d = rdata_s;
          bcnt_d  = BCNT_LOAD;
          state_d = UART_START;
        end else begin
          state_d = UART_IDLE;
        end
      end
      UART_START: begin
        if (bcnt_zero_s) begin
          bidx_d  = 3'd0;
          bcnt_d  = BCNT_LOAD;
          state_d = UART_DATA;
        end else begin
          bcnt_d = bcnt_q - BCNT_ONE;
        end
      end
      UART_DATA: begin
        if (bcnt_zero_s) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          bcnt_d  = BCNT_LOAD;
          if (bidx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q - BCNT_ONE;
        end
      end
      UART_STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (bcnt_zero_s) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            shreg_d = rdata_s;
            bcnt_d  = BCNT_LOAD;
            state_d = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q - BCNT_ONE;
        end
      end
      default: begin
        state_d = UART_IDLE;
      end
    endcase
  end

  // Line level follows the next state so uart_tx stays a plain flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shreg_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= UART_IDLE;
      bcnt_q     <= {BW{1'b0}};
      bidx_q     <= 3'd0;
      shreg_q    <= 8'd0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign uart_tx    = tx_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_s;
  assign busy       = (count_s != {CW{1'b0}}) || (state_q != UART_IDLE);

endmodule
